// File: rtl/aib_sr_pkg.sv
// Shared constants, state encoding and frame-image builder for the AIB
// sideband shift-register blocks.
package aib_sr_pkg;

    localparam int unsigned SL_SR_LEN = 73;
    localparam int unsigned MS_SR_LEN = 81;

    localparam int unsigned SL_OSC_TRANSFER_EN_IDX = 72;
    localparam int unsigned SL_RX_TRANSFER_EN_IDX  = 70;
    localparam int unsigned SL_RX_DLL_LOCK_IDX     = 68;
    localparam int unsigned SL_TX_TRANSFER_EN_IDX  = 64;
    localparam int unsigned SL_TX_DCD_CAL_DONE_IDX = 31;

    localparam logic [6:0] SL_CNT_LAST = 7'(SL_SR_LEN - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } sr_tx_state_e;

    typedef struct packed {
        logic osc_transfer_en;
        logic rx_transfer_en;
        logic rx_dll_lock;
        logic tx_transfer_en;
        logic tx_dcd_cal_done;
    } sl_status_t;

    function automatic logic [SL_SR_LEN-1:0] sl_frame_image(input sl_status_t st);
        logic [SL_SR_LEN-1:0] img;
        img                         = '0;
        img[SL_OSC_TRANSFER_EN_IDX] = st.osc_transfer_en;
        img[SL_RX_TRANSFER_EN_IDX]  = st.rx_transfer_en;
        img[SL_RX_DLL_LOCK_IDX]     = st.rx_dll_lock;
        img[SL_TX_TRANSFER_EN_IDX]  = st.tx_transfer_en;
        img[SL_TX_DCD_CAL_DONE_IDX] = st.tx_dcd_cal_done;
        return img;
    endfunction

endpackage

// File: rtl/aib_sync.sv
// Single-bit flop-chain synchronizer with asynchronous active-high clear.
module aib_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    // Depths below two give no metastability protection, so clamp.
    localparam int unsigned N = (STAGES < 2) ? 2 : STAGES;

    logic [N-1:0] chain;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= '0;
        end else begin
            chain <= {chain[N-2:0], d};
        end
    end

    assign q = chain[N-1];

endmodule

// File: rtl/aib_sl_shift_reg_tx.sv
// Slave-side AIB sideband transmitter: serializes synced status bits into a
// 73-bit frame, MSB first, with a one-cycle load pulse at each frame boundary.
//
// state | meaning
// IDLE  | not transmitting; data and load held low, waiting for i_en
// RUN   | shifting a frame out; i_en re-sampled only when cnt_q reaches 0
module aib_sl_shift_reg_tx
    import aib_sr_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             i_sl_sr_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_sl_osc_transfer_en,
    input  logic             i_sl_rx_transfer_en,
    input  logic             i_sl_rx_dll_lock,
    input  logic             i_sl_tx_transfer_en,
    input  logic             i_sl_tx_dcd_cal_done,
    output logic             o_sl_sr_data,
    output logic             o_sl_sr_load,
    output logic [CNT_W-1:0] o_frame_cnt,
    output logic             o_idle
);

    logic [4:0]           status_raw;
    logic [4:0]           status_sync;
    sl_status_t           status;
    sr_tx_state_e         state_q;
    sr_tx_state_e         state_d;
    logic [6:0]           cnt_q;
    logic [SL_SR_LEN-1:0] sr_q;
    logic                 load_q;
    logic [CNT_W-1:0]     frame_cnt_q;
    logic                 cnt_zero;
    logic                 boundary;
    logic                 shift_en;
    logic                 frame_done;

    assign status_raw = {i_sl_osc_transfer_en, i_sl_rx_transfer_en, i_sl_rx_dll_lock,
                         i_sl_tx_transfer_en, i_sl_tx_dcd_cal_done};

    for (genvar i = 0; i < 5; i++) begin : g_sync
        aib_sync #(
            .STAGES (SYNC_STAGES)
        ) u_sync (
            .clk (i_sl_sr_clk),
            .rst (i_rst),
            .d   (status_raw[i]),
            .q   (status_sync[i])
        );
    end

    assign status   = sl_status_t'(status_sync);
    assign cnt_zero = (cnt_q == 7'd0);

    always_ff @(posedge i_sl_sr_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (i_en) state_d = RUN;
            RUN:  if (cnt_zero && !i_en) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        boundary   = 1'b0;
        shift_en   = 1'b0;
        frame_done = 1'b0;
        case (state_q)
            IDLE: boundary = i_en;
            RUN: begin
                if (cnt_zero) begin
                    frame_done = 1'b1;
                    boundary   = i_en;
                end else begin
                    shift_en = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // A frame that ends without a successor still gets a load pulse so the
    // receiver captures it; otherwise the last frame would be lost.
    always_ff @(posedge i_sl_sr_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q  <= SL_CNT_LAST;
            sr_q   <= '0;
            load_q <= 1'b0;
        end else if (boundary) begin
            cnt_q  <= SL_CNT_LAST;
            sr_q   <= sl_frame_image(status);
            load_q <= 1'b1;
        end else if (shift_en) begin
            cnt_q  <= cnt_q - 7'd1;
            sr_q   <= {sr_q[SL_SR_LEN-2:0], sr_q[0]};
            load_q <= 1'b0;
        end else begin
            cnt_q  <= SL_CNT_LAST;
            sr_q   <= '0;
            load_q <= frame_done;
        end
    end

    always_ff @(posedge i_sl_sr_clk or posedge i_rst) begin
        if (i_rst) begin
            frame_cnt_q <= '0;
        end else if (frame_done && (frame_cnt_q != '1)) begin
            frame_cnt_q <= frame_cnt_q + CNT_W'(1);
        end
    end

    assign o_sl_sr_data = sr_q[SL_SR_LEN-1];
    assign o_sl_sr_load = load_q;
    assign o_frame_cnt  = frame_cnt_q;
    assign o_idle       = (state_q == IDLE);

endmodule

// File: tb/tb_aib_sl_shift_reg_tx.sv
// Directed self-checking bench for aib_sl_shift_reg_tx with a reference
// slave-frame receiver on the serial output.
module tb_aib_sl_shift_reg_tx;

    localparam logic [72:0] FULL   = 73'h1_51_0000_0000_8000_0000;
    localparam logic [72:0] NODCD  = 73'h1_51_0000_0000_0000_0000;
    localparam logic [72:0] ONLY68 = 73'h0_10_0000_0000_0000_0000;

    logic        clk = 1'b0;
    logic        rst, en, osc, rxte, dll, txte, dcd;
    logic        data, load, idle;
    logic [15:0] fc;
    logic        rst2, en2;
    logic        data2, load2, idle2;
    logic [3:0]  fc2;

    logic [72:0] rxsr = '0;
    logic [72:0] cap  = '0;
    logic [72:0] img;

    int total = 0;
    int bad   = 0;
    int pos   = 0;
    int exp_fc = 0;

    always #5 clk = ~clk;

    aib_sl_shift_reg_tx #(.SYNC_STAGES(2), .CNT_W(16)) dut (
        .i_sl_sr_clk          (clk),
        .i_rst                (rst),
        .i_en                 (en),
        .i_sl_osc_transfer_en (osc),
        .i_sl_rx_transfer_en  (rxte),
        .i_sl_rx_dll_lock     (dll),
        .i_sl_tx_transfer_en  (txte),
        .i_sl_tx_dcd_cal_done (dcd),
        .o_sl_sr_data         (data),
        .o_sl_sr_load         (load),
        .o_frame_cnt          (fc),
        .o_idle               (idle)
    );

    aib_sl_shift_reg_tx #(.SYNC_STAGES(2), .CNT_W(4)) dut_sat (
        .i_sl_sr_clk          (clk),
        .i_rst                (rst2),
        .i_en                 (en2),
        .i_sl_osc_transfer_en (1'b0),
        .i_sl_rx_transfer_en  (1'b0),
        .i_sl_rx_dll_lock     (1'b0),
        .i_sl_tx_transfer_en  (1'b0),
        .i_sl_tx_dcd_cal_done (1'b0),
        .o_sl_sr_data         (data2),
        .o_sl_sr_load         (load2),
        .o_frame_cnt          (fc2),
        .o_idle               (idle2)
    );

    // Receiver: on a load it latches the 73 bits seen before that cycle.
    always @(posedge clk) begin
        if (load) cap <= rxsr;
        rxsr <= {rxsr[71:0], data};
    end

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_steps(input int n);
        repeat (n) begin
            @(negedge clk);
            pos++;
            if (pos == 73) begin
                pos = 0;
                exp_fc++;
            end
        end
    endtask

    initial begin
        rst = 1'b1; rst2 = 1'b1; en = 1'b0; en2 = 1'b0;
        osc = 1'b0; rxte = 1'b0; dll = 1'b0; txte = 1'b0; dcd = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_data", data, 0);
        chk("rst_load", load, 0);
        chk("rst_fc", fc, 0);
        chk("rst_idle", idle, 1);
        chk("rst_fc2", fc2, 0);
        chk("rst_idle2", idle2, 1);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_no_en", idle, 1);

        // only rx_dll_lock set: single 1 at position 4 of each frame
        dll = 1'b1;
        repeat (3) @(negedge clk);
        chk("t1_no_load_before_en", load, 0);
        en = 1'b1;
        @(negedge clk);
        pos = 0;
        chk("t1_first_load_idle", idle, 0);
        for (int k = 0; k < 219; k++) begin
            chk("t1_load", load, (pos == 0));
            chk("t1_data", data, (pos == 4));
            run_steps(1);
        end
        chk("t1_fc", fc, exp_fc);

        // all inputs high; receiver sees full frame on every later load
        osc = 1'b1; rxte = 1'b1; txte = 1'b1; dcd = 1'b1;
        run_steps(74);
        chk("t2_cap_prev", cap, ONLY68);
        for (int f = 0; f < 3; f++) begin
            run_steps(73);
            chk("t2_cap_full", cap, FULL);
        end
        chk("t2_fc", fc, exp_fc);

        // dcd_cal_done raised mid-frame: current frame unchanged
        dcd = 1'b0;
        run_steps(72);
        run_steps(30);
        dcd = 1'b1;
        for (int k = 0; k < 116; k++) begin
            img = (k < 43) ? NODCD : FULL;
            chk("t3_data", data, img[72 - pos]);
            run_steps(1);
        end
        chk("t3_fc", fc, exp_fc);

        // drop enable at cnt_q = 40
        run_steps(32);
        en = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            chk("t4_load_mid", load, 0);
            chk("t4_idle_mid", idle, 0);
        end
        @(negedge clk);
        exp_fc++;
        chk("t4_last_load", load, 1);
        chk("t4_idle", idle, 1);
        chk("t4_data", data, 0);
        chk("t4_fc", fc, exp_fc);
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            chk("t4_after_load", load, 0);
            chk("t4_after_data", data, 0);
            chk("t4_after_idle", idle, 1);
        end
        chk("t4_fc_hold", fc, exp_fc);

        // disable exactly at the boundary
        en = 1'b1;
        @(negedge clk);
        pos = 0;
        chk("t5_load", load, 1);
        chk("t5_data_msb", data, 1);
        chk("t5_idle", idle, 0);
        run_steps(72);
        en = 1'b0;
        @(negedge clk);
        exp_fc++;
        chk("t5_close_load", load, 1);
        chk("t5_close_idle", idle, 1);
        chk("t5_close_data", data, 0);
        chk("t5_fc", fc, exp_fc);
        @(negedge clk);
        chk("t5_no_new_load", load, 0);
        chk("t5_no_new_data", data, 0);

        // reset with cnt_q = 20
        en = 1'b1;
        @(negedge clk);
        pos = 0;
        run_steps(52);
        #2 rst = 1'b1;
        #1;
        chk("t6_async_data", data, 0);
        chk("t6_async_load", load, 0);
        chk("t6_async_fc", fc, 0);
        chk("t6_async_idle", idle, 1);
        en = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("t6_rst_load", load, 0);
        end
        rst = 1'b0;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            chk("t6_post_load", load, 0);
            chk("t6_post_idle", idle, 1);
        end
        chk("t6_post_fc", fc, 0);

        // 4-bit counter saturation
        rst2 = 1'b0;
        en2  = 1'b1;
        @(negedge clk);
        chk("t7_load2", load2, 1);
        repeat (73 * 14) @(negedge clk);
        chk("t7_fc2_14", fc2, 14);
        repeat (73 * 6) @(negedge clk);
        chk("t7_fc2_sat", fc2, 15);
        repeat (146) @(negedge clk);
        chk("t7_fc2_hold", fc2, 15);
        chk("t7_idle2", idle2, 0);
        chk("t7_data2", data2, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
